// File: rtl/shot_sequencer_if.sv
// Board store port between shot_sequencer (master) and the 10x10 cell memory (slave).
// Reads have one cycle of latency; writes are single-cycle strobes.
interface shot_sequencer_if;
    logic [6:0] rd_addr;
    logic [1:0] rd_data;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [1:0] wr_data;

    modport master (
        output rd_addr,
        input  rd_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/shot_sequencer.sv
// Debounces the fire button and runs one read-modify-write per shot, committing the
// write only during vertical blanking; owns the turn/hit counters and sticky win/lose.
module shot_sequencer #(
    parameter int ROWS            = 10,
    parameter int COLS            = 10,
    parameter int TURNS           = 20,
    parameter int SHIP_CELLS      = 17,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_c,
    input  logic [3:0]              cur_row,
    input  logic [3:0]              cur_col,
    input  logic                    vblank,
    shot_sequencer_if.master        bus,
    output logic [4:0]              turns_left,
    output logic [4:0]              hits,
    output logic                    win,
    output logic                    lose,
    output logic                    busy
);
    localparam int                 CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]         ROWS_L   = 4'(ROWS);
    localparam logic [3:0]         COLS_L   = 4'(COLS);
    localparam logic [4:0]         TURNS_L  = 5'(TURNS);
    localparam logic [4:0]         HITS_WIN = 5'(SHIP_CELLS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_WAIT_VB = 3'd3,
        ST_WRITE   = 3'd4
    } state_e;

    logic             sync1_q, sync2_q, db_q, db_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fire_s;
    logic             in_range_s;
    logic [6:0]       shot_addr_s;

    state_e     state_q,   state_d;
    logic [6:0] rd_addr_q, rd_addr_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [1:0] wr_data_q, wr_data_d;
    logic       wr_en_q,   wr_en_d;
    logic [4:0] turns_q,   turns_d;
    logic [4:0] hits_q,    hits_d;
    logic       win_q,     win_d;
    logic       lose_q,    lose_d;
    logic       busy_q;

    // Two-flop synchroniser followed by a stable-level debounce counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_c;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            if (sync2_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                db_q  <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign fire_s      = db_q & ~db_prev_q;
    assign in_range_s  = (cur_row < ROWS_L) && (cur_col < COLS_L);
    assign shot_addr_s = 7'(cur_row) * 7'(COLS) + 7'(cur_col);

    // Shot sequencing: next state, board port and score updates
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        turns_d   = turns_q;
        hits_d    = hits_q;
        win_d     = win_q;
        lose_d    = lose_q;
        case (state_q)
            ST_IDLE: begin
                if (fire_s && !win_q && !lose_q && in_range_s) begin
                    rd_addr_d = shot_addr_s;
                    state_d   = ST_READ;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Codes 10/11 mean the cell was already shot: the press costs nothing
                if (bus.rd_data[1]) begin
                    state_d   = ST_IDLE;
                end else begin
                    wr_data_d = {1'b1, bus.rd_data[0]};
                    wr_addr_d = rd_addr_q;
                    state_d   = ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: begin
                if (vblank) begin
                    wr_en_d = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_WAIT_VB;
                end
            end
            ST_WRITE: begin
                turns_d = turns_q - 5'd1;
                hits_d  = hits_q + {4'd0, wr_data_q[0]};
                win_d   = (hits_d == HITS_WIN);
                lose_d  = (turns_d == 5'd0) && (hits_d != HITS_WIN);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= 7'd0;
            wr_addr_q <= 7'd0;
            wr_data_q <= 2'd0;
            wr_en_q   <= 1'b0;
            turns_q   <= TURNS_L;
            hits_q    <= 5'd0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            turns_q   <= turns_d;
            hits_q    <= hits_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_en   = wr_en_q;
    assign turns_left  = turns_q;
    assign hits        = hits_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_shot_sequencer.sv
// Self-checking bench for shot_sequencer: board memory model, shot-level reference
// model of the game rules, directed scenarios and randomized games.
module tb_shot_sequencer;
    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int TURNS = 20;
    localparam int SHIP = 17;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_c = 1'b0;
    logic [3:0] cur_row = 4'd0;
    logic [3:0] cur_col = 4'd0;
    logic       vblank = 1'b1;
    logic [4:0] turns_left, hits;
    logic       win, lose, busy;

    shot_sequencer_if bus ();

    shot_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .TURNS(TURNS), .SHIP_CELLS(SHIP), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .btn_c(btn_c), .cur_row(cur_row), .cur_col(cur_col),
        .vblank(vblank), .bus(bus), .turns_left(turns_left), .hits(hits),
        .win(win), .lose(lose), .busy(busy)
    );

    always #5 clk = ~clk;

    // board memory with one cycle read latency
    logic [1:0] mem [0:127];
    logic [1:0] img [0:127];
    logic       load_en = 1'b0;
    always @(posedge clk) begin
        bus.rd_data <= mem[bus.rd_addr];
        if (load_en) begin
            for (int i = 0; i < 128; i++) mem[i] <= img[i];
        end else if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitor
    int   wr_cnt = 0, wr_cyc = 0, bad_wr = 0;
    int   rise_cnt = 0, rise_cyc = 0, fall_cyc = 0, rise_rd_addr = 0;
    int   wr_a = 0, wr_d = 0;
    logic busy_d = 1'b0;
    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_cnt++;
            wr_cyc = cyc;
            wr_a   = int'(bus.wr_addr);
            wr_d   = int'(bus.wr_data);
            if (!vblank) bad_wr++;
        end
        if (busy && !busy_d) begin
            rise_cnt++;
            rise_cyc     = cyc;
            rise_rd_addr = int'(bus.rd_addr);
        end
        if (!busy && busy_d) fall_cyc = cyc;
        busy_d = busy;
    end

    // reference model state
    logic [1:0] ref_b [0:127];
    int m_turns, m_hits, m_rd;
    bit m_win, m_lose;

    int n_chk = 0, n_pass = 0;
    int vb_rise_cyc = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_c = 1'b0; vblank = 1'b1; cur_row = 4'd0; cur_col = 4'd0;
        reset = 1'b1; load_en = 1'b1;
        tick(1);
        load_en = 1'b0;
        tick(4);
        reset = 1'b0;
        for (int i = 0; i < 128; i++) ref_b[i] = img[i];
        m_turns = TURNS; m_hits = 0; m_win = 1'b0; m_lose = 1'b0; m_rd = 0;
        tick(2);
    endtask

    task automatic check_score(input string tag);
        check_eq({tag, "_turns"}, int'(turns_left), m_turns);
        check_eq({tag, "_hits"}, int'(hits), m_hits);
        check_eq({tag, "_win"}, int'(win), int'(m_win));
        check_eq({tag, "_lose"}, int'(lose), int'(m_lose));
    endtask

    task automatic check_board();
        int bad;
        bad = 0;
        for (int i = 0; i < ROWS * COLS; i++) if (mem[i] != ref_b[i]) bad++;
        check_eq("board_cells_differing", bad, 0);
    endtask

    // one press at (r,c); vblank held low for vb_low extra cycles after the press
    task automatic shot(input int r, input int c, input int vb_low);
        bit valid, writes;
        int a, rc0, wc0, bad0, n;
        logic [1:0] code, exp_wd;
        valid  = !m_win && !m_lose && r < ROWS && c < COLS;
        a      = r * COLS + c;
        writes = 1'b0;
        exp_wd = 2'b00;
        if (valid) begin
            m_rd = a;
            code = ref_b[a];
            if (!code[1]) begin
                writes   = 1'b1;
                exp_wd   = {1'b1, code[0]};
                ref_b[a] = exp_wd;
                m_turns--;
                m_hits += int'(code[0]);
                if (m_hits == SHIP) m_win = 1'b1;
                else if (m_turns == 0) m_lose = 1'b1;
            end
        end
        rc0 = rise_cnt; wc0 = wr_cnt; bad0 = bad_wr;
        cur_row = 4'(r); cur_col = 4'(c);
        vblank  = (vb_low == 0);
        btn_c = 1'b1;
        tick(10);
        btn_c = 1'b0;
        tick(8);
        if (vb_low > 0) begin
            tick(vb_low);
            if (writes) check_eq("busy_while_waiting_vb", int'(busy), 1);
            check_eq("no_write_outside_vb", wr_cnt - wc0, 0);
            vblank = 1'b1;
            vb_rise_cyc = cyc;
        end
        n = 0;
        while (busy && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) check_eq("idle_timeout", 1, 0);
        tick(3);
        check_eq("reads_started", rise_cnt - rc0, valid ? 1 : 0);
        check_eq("writes_issued", wr_cnt - wc0, writes ? 1 : 0);
        check_eq("rd_addr", int'(bus.rd_addr), m_rd);
        if (valid) check_eq("rd_addr_at_read", rise_rd_addr, a);
        if (writes) begin
            check_eq("wr_addr", wr_a, a);
            check_eq("wr_data", wr_d, int'(exp_wd));
            if (vb_low == 0) check_eq("write_latency", wr_cyc - rise_cyc, 3);
            else check_eq("write_after_vb_rise", wr_cyc - vb_rise_cyc, 1);
        end else if (valid) begin
            check_eq("reshot_busy_len", fall_cyc - rise_cyc, 2);
        end
        check_eq("write_in_active_video", bad_wr - bad0, 0);
        check_score("shot");
    endtask

    initial begin
        int wc0, rc0;
        // game 1: directed basics
        for (int i = 0; i < 128; i++) img[i] = 2'b00;
        img[23] = 2'b01;
        do_reset();
        tick(20);
        check_score("reset");
        check_eq("reset_wr_en", int'(bus.wr_en), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_rd_addr", int'(bus.rd_addr), 0);
        shot(2, 3, 0);
        shot(2, 3, 0);
        shot(5, 5, 50);
        rc0 = rise_cnt;
        for (int k = 0; k < 5; k++) begin
            btn_c = 1'b1; tick(3);
            btn_c = 1'b0; tick(3);
        end
        tick(8);
        check_eq("glitch_no_fire", rise_cnt - rc0, 0);
        shot(12, 0, 0);
        shot(0, 12, 0);
        shot(9, 9, 0);
        check_board();

        // reset during WAIT_VB aborts without a write
        vblank = 1'b0; cur_row = 4'd7; cur_col = 4'd7;
        wc0 = wr_cnt;
        btn_c = 1'b1; tick(10); btn_c = 1'b0; tick(4);
        check_eq("abort_busy_before_reset", int'(busy), 1);
        reset = 1'b1; tick(3); reset = 1'b0; tick(6);
        vblank = 1'b1; tick(4);
        check_eq("abort_no_write", wr_cnt - wc0, 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_turns", int'(turns_left), TURNS);

        // game 2: final turn makes the final hit
        for (int i = 0; i < 128; i++) img[i] = (i < SHIP) ? 2'b01 : 2'b00;
        do_reset();
        for (int k = 0; k < 3; k++) shot(5, k, 0);
        for (int k = 0; k < SHIP; k++) shot(k / COLS, k % COLS, (k == SHIP - 1) ? 5 : 0);
        check_eq("final_win", int'(win), 1);
        check_eq("final_lose", int'(lose), 0);
        shot(9, 9, 0);
        check_board();

        // game 3: twenty misses lose, then presses are dropped
        for (int i = 0; i < 128; i++) img[i] = 2'b00;
        do_reset();
        for (int k = 0; k < TURNS; k++) shot(3 + k / COLS, k % COLS, 0);
        check_eq("lost", int'(lose), 1);
        shot(8, 8, 0);
        check_board();

        // randomized games
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 128; i++) img[i] = 2'($urandom_range(0, 3));
            do_reset();
            for (int k = 0; k < 30; k++)
                shot($urandom_range(0, 11), $urandom_range(0, 11),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0);
            check_board();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
